// File: rtl/multu_seq_ctrl.sv
// Sequential unsigned shift-add multiplier that owns HI/LO and stalls MFHI/MFLO/MULTU on an unfinished product.
// Optional: define MULTU_EARLY_TERM_EN to finish as soon as the remaining multiplier bits are zero.
module multu_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             mf_req,
    input  logic             mf_sel,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] mf_data,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [WIDTH:0]     s;
    logic [2*WIDTH-1:0] acc_step;
    logic               last_iter;

    // acc_lo's low bits are the unconsumed multiplier; the product fills in from the top.
    always_comb begin
        s = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, mcand} : '0);
    end

`ifdef MULTU_EARLY_TERM_EN
    logic [WIDTH-1:0]   rem_mask;
    logic [CNT_W:0]     sh;
    logic [2*WIDTH:0]   wide;

    // If no set bit remains above the one consumed now, the rest of the run only shifts.
    always_comb begin
        rem_mask  = {WIDTH{1'b1}} >> (cnt + 1'b1);
        last_iter = ((acc_lo >> 1) & rem_mask) == '0;
        sh        = (CNT_W+1)'(WIDTH) - {1'b0, cnt};
        wide      = {s, acc_lo} >> (last_iter ? sh : (CNT_W+1)'(1));
        acc_step  = wide[2*WIDTH-1:0];
    end
`else
    always_comb begin
        last_iter = (cnt == CNT_W'(WIDTH-1));
        acc_step  = {s, acc_lo[WIDTH-1:1]};
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start)
                cnt <= '0;
            else if (state == RUN)
                cnt <= cnt + 1'b1;
            if (state == COMMIT) begin
                hi <= acc_hi;
                lo <= acc_lo;
            end
        end
    end

    // Working registers carry no reset: they are always reloaded on accept before use.
    always_ff @(posedge clk) begin
        if (state == IDLE && start) begin
            mcand  <= op_a;
            acc_hi <= '0;
            acc_lo <= op_b;
        end else if (state == RUN) begin
            {acc_hi, acc_lo} <= acc_step;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_iter) state_nxt = COMMIT;
            COMMIT:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy    = (state != IDLE);
        done    = (state == COMMIT);
        stall   = busy && (mf_req || start);
        mf_data = mf_sel ? hi : lo;
    end

endmodule

// File: tb/tb_multu_seq_ctrl.sv
// Scoreboard bench for multu_seq_ctrl: accepted MULTUs push expected HI/LO and done cycle; a monitor checks on done.
module tb_multu_seq_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] op_a, op_b;
    logic         mf_req, mf_sel;
    logic         busy, done, stall;
    logic [W-1:0] mf_data, hi, lo;

    multu_seq_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .reset(reset), .start(start), .op_a(op_a), .op_b(op_b),
        .mf_req(mf_req), .mf_sel(mf_sel), .busy(busy), .done(done), .stall(stall),
        .mf_data(mf_data), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        int           dcyc;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   last_acc = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int lat(input logic [W-1:0] b);
`ifdef MULTU_EARLY_TERM_EN
        int k = 0;
        for (int i = 0; i < W; i++) if (b[i]) k = i;
        return k + 2;
`else
        return W + 1;
`endif
    endfunction

    // Monitor: on each done, pop expectation, check the cycle, then HI/LO one cycle later.
    exp_t pend;
    bit   chk_pending = 0;
    always @(negedge clk) begin
        if (chk_pending) begin
            chk("commit_hi", 64'(hi), 64'(pend.hi));
            chk("commit_lo", 64'(lo), 64'(pend.lo));
            chk_pending = 0;
        end
        if (done) begin
            if (q.size() == 0) begin
                chk("unexpected_done", 64'(1), 64'(0));
            end else begin
                pend = q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(pend.dcyc));
                chk_pending = 1;
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] eh, input logic [W-1:0] el, input bit mf);
        exp_t e;
        bit   acc = 0;
        @(posedge clk); #1;
        start = 1'b1; op_a = a; op_b = b; mf_req = mf;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            if (!busy) begin
                acc = 1;
                chk("accept_stall", 64'(stall), 64'(0));
                last_acc = cyc;
                e.hi = eh; e.lo = el; e.dcyc = cyc + lat(b);
                q.push_back(e);
            end else if (i == 0) begin
                chk("start_busy_stall", 64'(stall), 64'(1));
            end
            @(posedge clk); #1;
        end
        start = 1'b0; mf_req = 1'b0;
        if (!acc) chk("issue_timeout", 64'(0), 64'(1));
    endtask

    task automatic wait_idle();
        bit idle = 0;
        for (int i = 0; i < 200 && !idle; i++) begin
            @(negedge clk);
            if (!busy) idle = 1;
        end
        if (!idle) chk("idle_timeout", 64'(0), 64'(1));
    endtask

    initial begin
        int first_acc;
        int drop;
        reset = 1'b0; start = 1'b0; op_a = '0; op_b = '0; mf_req = 1'b0; mf_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;

        @(negedge clk);
        chk("rst_hi", 64'(hi), 64'(0));
        chk("rst_lo", 64'(lo), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_stall", 64'(stall), 64'(0));
        chk("rst_mf_data", 64'(mf_data), 64'(0));

        // 7*6 with an MFHI/MFLO in the same cycle from IDLE: start wins, no stall
        issue(32'd7, 32'd6, 32'd0, 32'd42, 1'b1);
        @(negedge clk);
        chk("busy_after_start", 64'(busy), 64'(1));
        wait_idle();

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
        wait_idle();
        issue(32'h8000_0000, 32'd2, 32'd1, 32'd0, 1'b0);
        wait_idle();
        issue(32'h1234_5678, 32'h10, 32'd1, 32'h2345_6780, 1'b0);
        wait_idle();

        // MFLO right behind MULTU(3,5) is held until the product lands
        issue(32'd3, 32'd5, 32'd0, 32'd15, 1'b0);
        mf_req = 1'b1; mf_sel = 1'b0;
        @(negedge clk);
        chk("mf_stall", 64'(stall), 64'(1));
        drop = -1;
        for (int i = 0; i < 200 && drop < 0; i++) begin
            @(negedge clk);
            if (!stall) drop = cyc;
        end
        chk("mf_stall_release_cycle", 64'(drop), 64'(last_acc + lat(32'd5) + 1));
        chk("mf_release_busy", 64'(busy), 64'(0));
        chk("mflo_data", 64'(mf_data), 64'(15));
        #1 mf_sel = 1'b1;
        #1 chk("mfhi_data", 64'(mf_data), 64'(0));
        @(posedge clk); #1 mf_req = 1'b0; mf_sel = 1'b0;

        // second MULTU during a run waits for the first IDLE cycle
        issue(32'd4, 32'd4, 32'd0, 32'd16, 1'b0);
        first_acc = last_acc;
        issue(32'd2, 32'd9, 32'd0, 32'd18, 1'b0);
        chk("second_accept_cycle", 64'(last_acc), 64'(first_acc + lat(32'd4) + 1));
        wait_idle();

        // zero and one multipliers (short under early termination)
        issue(32'd5, 32'd0, 32'd0, 32'd0, 1'b0);
        wait_idle();
        issue(32'd77, 32'd1, 32'd0, 32'd77, 1'b0);
        wait_idle();
        @(negedge clk);
        chk("hi_before_abort", 64'(hi), 64'(0));
        chk("lo_before_abort", 64'(lo), 64'(77));

        // reset mid-run aborts: HI/LO cleared, no done pulse
        issue(32'd100, 32'd100, 32'd0, 32'd10000, 1'b0);
        repeat (9) @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        @(negedge clk);
        chk("abort_hi", 64'(hi), 64'(0));
        chk("abort_lo", 64'(lo), 64'(0));
        chk("abort_busy", 64'(busy), 64'(0));
        chk("abort_done", 64'(done), 64'(0));
        @(posedge clk); #1 reset = 1'b1;
        repeat (50) @(negedge clk);
        chk("post_abort_busy", 64'(busy), 64'(0));
        chk("post_abort_lo", 64'(lo), 64'(0));
        chk("queue_drained", 64'(q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
